// File: rtl/aria_pkg.sv
// -----------------------------------------------------------------------------
// aria_pkg
// Shared definitions for the ARIA inverse S1 substitution unit:
//   - state_t           : FSM state encoding of the iterative substitutor
//   - S1_INV_AFFINE_C   : constant added by the S1 inverse affine map
//   - ARIA_BLK_W        : ARIA block width in bits
// -----------------------------------------------------------------------------
package aria_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] S1_INV_AFFINE_C = 8'h05;
    localparam int         ARIA_BLK_W      = 128;

endpackage

// File: rtl/aria_gfinv.sv
// -----------------------------------------------------------------------------
// aria_gfinv
// Combinational multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1.
// Computed as a^254, which maps 0 to 0 without a special case.
// Ports:
//   i_a : input  [7:0] field element
//   o_y : output [7:0] inverse of i_a (0 for i_a == 0)
// -----------------------------------------------------------------------------
module aria_gfinv (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x240, w_x252;

    // Addition chain for the exponent 254.
    always_comb begin
        w_x2   = gf_mul(i_a, i_a);
        w_x3   = gf_mul(w_x2, i_a);
        w_x6   = gf_mul(w_x3, w_x3);
        w_x12  = gf_mul(w_x6, w_x6);
        w_x15  = gf_mul(w_x12, w_x3);
        w_x240 = w_x15;
        for (int k = 0; k < 4; k++) begin
            w_x240 = gf_mul(w_x240, w_x240);
        end
        w_x252 = gf_mul(w_x240, w_x12);
        o_y    = gf_mul(w_x252, w_x2);
    end

endmodule

// File: rtl/aria_sbox_s1_inv.sv
// -----------------------------------------------------------------------------
// aria_sbox_s1_inv
// Combinational byte S1^-1: inverse affine map followed by GF(2^8) inversion.
// Ports:
//   i_y : input  [7:0] byte to substitute
//   o_s : output [7:0] S1^-1(i_y)
// -----------------------------------------------------------------------------
module aria_sbox_s1_inv
    import aria_pkg::*;
(
    input  logic [7:0] i_y,
    output logic [7:0] o_s
);

    logic [7:0] w_t;

    always_comb begin
        w_t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_t[i] = i_y[(i + 2) % 8] ^ i_y[(i + 5) % 8] ^ i_y[(i + 7) % 8]
                   ^ S1_INV_AFFINE_C[i];
        end
    end

    aria_gfinv u_gfinv (
        .i_a (w_t),
        .o_y (o_s)
    );

endmodule

// File: rtl/aria_sbox_s1_inv_iter.sv
// -----------------------------------------------------------------------------
// aria_sbox_s1_inv_iter
// Iterative S1^-1 over a 128-bit ARIA block. LANES byte substitutors are
// time-shared; the block is rewritten in place, LANES bytes per cycle, over
// GROUPS = 16/LANES cycles. Valid/ready handshake on both sides.
// Optional feature macro ARIA_ISBOX_CLR_EN: when defined, the working register
// (and dout) is zeroed on the output handshake edge.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : input block valid
//   in_ready  : unit can accept a block (IDLE)
//   din       : input block, byte k = din[8k+7:8k]
//   out_valid : substituted block available (DONE)
//   out_ready : consumer accepts the block
//   dout      : result, byte k = S1^-1(din byte k)
// -----------------------------------------------------------------------------
module aria_sbox_s1_inv_iter
    import aria_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ARIA_BLK_W-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ARIA_BLK_W-1:0] dout
);

    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [ARIA_BLK_W-1:0] r_work;
    logic [ARIA_BLK_W-1:0] w_work_sub;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_last;
    logic [7:0]            w_lane_in  [LANES];
    logic [7:0]            w_lane_out [LANES];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign dout      = r_work;
    assign w_accept  = in_ready && in_valid;
    assign w_release = out_valid && out_ready;
    assign w_last    = (r_cnt == CNT_W'(GROUPS - 1));

    // Lane l works on byte cnt*LANES + l; select it from the working register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = 8'h00;
            for (int g = 0; g < GROUPS; g++) begin
                if (r_cnt == CNT_W'(g)) begin
                    w_lane_in[l] = r_work[(g * LANES + l) * 8 +: 8];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aria_sbox_s1_inv u_sbox (
            .i_y (w_lane_in[l]),
            .o_s (w_lane_out[l])
        );
    end

    // Working register with the current group's bytes replaced.
    always_comb begin
        w_work_sub = r_work;
        for (int b = 0; b < 16; b++) begin
            if (r_cnt == CNT_W'(b / LANES)) begin
                w_work_sub[b * 8 +: 8] = w_lane_out[b % LANES];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (w_release) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter saturates at GROUPS-1; it is re-cleared on the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_BUSY && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work <= '0;
        end else if (w_accept) begin
            r_work <= din;
        end else if (r_state == ST_BUSY) begin
            r_work <= w_work_sub;
        end
`ifdef ARIA_ISBOX_CLR_EN
        else if (w_release) begin
            r_work <= '0;
        end
`endif
    end

endmodule

// File: tb/tb_aria_sbox_s1_inv_iter.sv
module tb_aria_sbox_s1_inv_iter;

    localparam int LANES  = 4;
    localparam int GROUPS = 16 / LANES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    // behavioural model state
    bit           m_rdy  = 1'b1;
    bit           m_vld  = 1'b0;
    int           m_left = 0;
    logic [127:0] m_dout = '0;
    logic [127:0] m_pend = '0;

    aria_sbox_s1_inv_iter #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x & 256) x = x ^ 'h11B;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S1 by brute-force inversion plus AES affine; inverse by table flip.
    task automatic build_tables();
        logic [7:0] b, s;
        for (int a = 0; a < 256; a++) begin
            b = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
            end
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_t[a] = s;
            inv_t[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] inv_block(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = inv_t[v[k*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_block(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = fwd_t[v[k*8 +: 8]];
        return r;
    endfunction

    // Reference model: one accept, GROUPS busy cycles, DONE until handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy  = 1'b1;
            m_vld  = 1'b0;
            m_left = 0;
            m_dout = '0;
        end else if (m_rdy) begin
            if (in_valid) begin
                m_rdy  = 1'b0;
                m_left = GROUPS;
                m_pend = inv_block(din);
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_vld  = 1'b1;
                m_dout = m_pend;
            end
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
            m_rdy = 1'b1;
`ifdef ARIA_ISBOX_CLR_EN
            m_dout = '0;
`endif
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", 128'(in_ready), 128'(m_rdy));
        chk("cyc_out_valid", 128'(out_valid), 128'(m_vld));
        if (m_rdy || m_vld) chk("cyc_dout", dout, m_dout);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] blk, input int hold, input bit early,
                             output logic [127:0] res);
        int n;
        int lat;
        din      = blk;
        in_valid = 1'b1;
        if (early) out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 128'(n), 128'(0));
        tick();
        in_valid = 1'b0;
        din      = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(GROUPS));
        res = dout;
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_dout", dout, res);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_in_ready", 128'(in_ready), 128'(1));
        chk("post_out_valid", 128'(out_valid), 128'(0));
`ifdef ARIA_ISBOX_CLR_EN
        chk("post_dout_clr", dout, 128'h0);
`else
        chk("post_dout_keep", dout, res);
`endif
    endtask

    initial begin
        logic [127:0] res, a, b, blk;
        int hold;
        bit early;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        build_tables();

        // pin the model against known S-box values
        chk("pin_fwd00", 128'(fwd_t[8'h00]), 128'h63);
        chk("pin_inv00", 128'(inv_t[8'h00]), 128'h52);
        chk("pin_inv63", 128'(inv_t[8'h63]), 128'h00);
        chk("pin_inv7c", 128'(inv_t[8'h7C]), 128'h01);
        chk("pin_inv01", 128'(inv_t[8'h01]), 128'h09);
        chk("pin_inv52", 128'(inv_t[8'h52]), 128'h48);
        chk("pin_invff", 128'(inv_t[8'hFF]), 128'h7D);

        repeat (2) tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_dout", dout, 128'h0);
        rst = 1'b0;
        tick();

        // known answers
        run_block(128'h0, 3, 1'b0, res);
        chk("kat_zero", res, {16{8'h52}});
        run_block({{11{8'h00}}, 8'hFF, 8'h52, 8'h01, 8'h7C, 8'h63}, 0, 1'b0, res);
        chk("kat_vec", res, {{11{8'h52}}, 8'h7D, 8'h48, 8'h09, 8'h01, 8'h00});

        // backpressure
        a = {$urandom, $urandom, $urandom, $urandom};
        run_block(a, 10, 1'b0, res);
        chk("bp_result", res, inv_block(a));

        // busy lockout: a second block offered during BUSY must be ignored
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        din = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        din = b;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("lockout_valid", 128'(out_valid), 128'(1));
        chk("lockout_dout", dout, inv_block(a));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // asynchronous reset with cnt==2
        din = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_dout", dout, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        a = {$urandom, $urandom, $urandom, $urandom};
        run_block(a, 1, 1'b0, res);
        chk("arst_next", res, inv_block(a));

        // randomized round trip through the forward S1
        for (int it = 0; it < 300; it++) begin
            blk   = {$urandom, $urandom, $urandom, $urandom};
            early = ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : int'($urandom_range(0, 3));
            run_block(fwd_block(blk), hold, early, res);
            chk("roundtrip", res, blk);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
